mbu_bank_regs: RTL and testbench

Synchronous Memory Bank Unit holding eight 8-bit bank registers MB0–MB7 and an 8-bit MBP flags register. It supplies address extension bits AEXT[7:0] (AR[23:16]) to the address register. It is also reachable from the control unit over the IBUS (read/write addresses) and from I/O space &008–&00F via IN/OUT over DB. Explicit decode logic replaces the board's control ROM.

---
 rtl/mbu_pkg.sv | 27 ++
 rtl/mbu_bank_regs_if.sv | 37 +++
 rtl/mbu_decode.sv | 32 +++
 rtl/mbu_bank_regs.sv | 163 ++++++++++++++++
 tb/tb_mbu_bank_regs.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mbu_pkg.sv
// mbu_pkg: shared constants and types for the Memory Bank Unit.
//   NREGS      - number of bank registers (MB0..MB7)
//   ROMBIT     - AEXT bit driven by the front-panel ROM switch while disabled
//   RADDR_*    - control-unit read addresses of MB0 and the flags register
//   WADDR_*    - control-unit write addresses of MB0 and the flags register
//   IO_MBR_BASE- base of the bank-register window in system I/O space
package mbu_pkg;

  localparam int unsigned NREGS  = 8;
  localparam int unsigned ROMBIT = 7;

  localparam logic [4:0] RADDR_MBP       = 5'b01100;
  localparam logic [4:0] RADDR_MBP_FLAGS = 5'b01101;
  localparam logic [4:0] WADDR_MBP       = 5'b01100;
  localparam logic [4:0] WADDR_MBP_FLAGS = 5'b01101;

  localparam logic [7:0] IO_MBR_BASE = 8'h08;

  typedef logic [2:0] bank_idx_t;

  // True when the active-low decoder output selected by 'line' is asserted.
  // The whole output vector is consumed so unused lines are not left dangling.
  function automatic logic line_hit(input logic [7:0] y_n, input bank_idx_t line);
    return |(~y_n & (8'h01 << line));
  endfunction

endpackage

// File: rtl/mbu_bank_regs_if.sv
// mbu_bank_regs_if: bus bundle between the Memory Bank Unit and its surroundings.
//   CU side : t34, raddr, waddr, idxen, ir, ibus_in -> ibus_out, ibus_oe
//   I/O side: ab, db_in, nsysdev, nr, nw           -> db_out, db_oe
//   AR side : nfpram_rom                           -> aext, nwrite_ar_mbx
//   master drives the inputs (CPU/bench), slave is the bank unit.
interface mbu_bank_regs_if;
  logic       t34;
  logic [4:0] raddr;
  logic [4:0] waddr;
  logic       idxen;
  logic [2:0] ir;
  logic [7:0] ibus_in;
  logic [7:0] ibus_out;
  logic       ibus_oe;
  logic [7:0] ab;
  logic [7:0] db_in;
  logic [7:0] db_out;
  logic       db_oe;
  logic       nsysdev;
  logic       nr;
  logic       nw;
  logic       nfpram_rom;
  logic [7:0] aext;
  logic       nwrite_ar_mbx;

  modport master (
    output t34, raddr, waddr, idxen, ir, ibus_in, ab, db_in,
           nsysdev, nr, nw, nfpram_rom,
    input  ibus_out, ibus_oe, db_out, db_oe, aext, nwrite_ar_mbx
  );

  modport slave (
    input  t34, raddr, waddr, idxen, ir, ibus_in, ab, db_in,
           nsysdev, nr, nw, nfpram_rom,
    output ibus_out, ibus_oe, db_out, db_oe, aext, nwrite_ar_mbx
  );
endinterface

// File: rtl/mbu_decode.sv
// mbu_decode: 3-to-8 decoder, one active-high and two active-low enables,
// active-low outputs (74HC138 equivalent).
//   a     - select input
//   g1    - active-high enable
//   g2a_n - active-low enable
//   g2b_n - active-low enable
//   y_n   - outputs, y_n[a] low when all enables are asserted
module mbu_decode
  import mbu_pkg::*;
(
  input  bank_idx_t  a,
  input  logic       g1,
  input  logic       g2a_n,
  input  logic       g2b_n,
  output logic [7:0] y_n
);

  logic en_s;

  assign en_s = g1 & ~g2a_n & ~g2b_n;

  // Pull the addressed output low only while the decoder is enabled.
  always_comb begin
    y_n = 8'hFF;
    if (en_s) begin
      y_n[a] = 1'b0;
    end else begin
      y_n = 8'hFF;
    end
  end

endmodule

// File: rtl/mbu_bank_regs.sv
// mbu_bank_regs: Memory Bank Unit. Eight bank registers MB0..MB7 plus a flags
// register, reachable from the control unit over IBUS and from system I/O
// space &08-&0F over DB. Supplies AR[23:16] through aext.
//   clk3   - system clock, all state updates on the rising edge
//   nreset - asynchronous active-low reset
//   bus    - mbu_bank_regs_if.slave bundle (CU, I/O and AR signals)
// Until the first I/O access to the bank window the unit is disabled and all
// reads and aext return the front-panel ROM/RAM boot value instead of MBx.
module mbu_bank_regs
  import mbu_pkg::*;
(
  input  logic            clk3,
  input  logic            nreset,
  mbu_bank_regs_if.slave  bus
);

  logic [7:0] ab_dec_n_s, rd_dec_n_s, wr_dec_n_s, ar_dec_n_s;
  logic       niombr_s, rd_mbp_s, rd_flags_s, wr_mbp_s, wr_flags_s;
  logic       io_rd_s, io_wr_s, nwrite_ar_s;
  bank_idx_t  io_idx_s, sel_s;
  logic [7:0] rom_val_s;
  logic [7:0] mb_r [NREGS];
  logic [7:0] flags_r;
  logic       dis_r;

  // I/O window &08-&0F: ab[3] must match the base, ab[7] and ab[6:4] zero.
  mbu_decode u_ab_dec (
    .a     (bank_idx_t'(bus.ab[6:4] ^ IO_MBR_BASE[6:4])),
    .g1    (bus.ab[3] == IO_MBR_BASE[3]),
    .g2a_n (bus.nsysdev),
    .g2b_n (bus.ab[7]),
    .y_n   (ab_dec_n_s)
  );

  // CU read decode, enabled for raddr 01xxx inside the t34 window.
  mbu_decode u_rd_dec (
    .a     (bus.raddr[2:0]),
    .g1    (bus.raddr[3]),
    .g2a_n (bus.raddr[4]),
    .g2b_n (bus.t34),
    .y_n   (rd_dec_n_s)
  );

  // CU write decode for waddr 01xxx.
  mbu_decode u_wr_dec (
    .a     (bus.waddr[2:0]),
    .g1    (bus.waddr[3]),
    .g2a_n (bus.waddr[4]),
    .g2b_n (1'b0),
    .y_n   (wr_dec_n_s)
  );

  // Write-AR-with-bank group: waddr 4..7.
  mbu_decode u_ar_dec (
    .a     (bus.waddr[4:2]),
    .g1    (1'b1),
    .g2a_n (1'b0),
    .g2b_n (1'b0),
    .y_n   (ar_dec_n_s)
  );

  assign niombr_s    = ~line_hit(ab_dec_n_s, 3'd0);
  assign rd_mbp_s    = line_hit(rd_dec_n_s, RADDR_MBP[2:0]);
  assign rd_flags_s  = line_hit(rd_dec_n_s, RADDR_MBP_FLAGS[2:0]);
  assign wr_mbp_s    = line_hit(wr_dec_n_s, WADDR_MBP[2:0]);
  assign wr_flags_s  = line_hit(wr_dec_n_s, WADDR_MBP_FLAGS[2:0]);
  assign nwrite_ar_s = ~line_hit(ar_dec_n_s, 3'd1);

  assign io_idx_s = bus.ab[2:0];
  assign io_rd_s  = ~niombr_s & ~bus.nr;
  // A read wins over a write when nr and nw are both low.
  assign io_wr_s  = ~niombr_s & ~bus.nw & bus.nr;

  // Indexed bank only for the fourth AR-write slot with IR indexing active.
  assign sel_s = (bus.idxen && (bus.waddr[1:0] == 2'b11)) ? bus.ir
                                                          : {1'b0, bus.waddr[1:0]};

  // Boot value presented while disabled: ROM switch on ROMBIT, rest zero.
  always_comb begin
    rom_val_s         = 8'h00;
    rom_val_s[ROMBIT] = bus.nfpram_rom;
  end

  // Bank register file; a CU write to MB0 takes priority over an OUT to MB0.
  always_ff @(posedge clk3 or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NREGS; i++) mb_r[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if ((i == 0) && wr_mbp_s) begin
          mb_r[i] <= bus.ibus_in;
        end else if (io_wr_s && (io_idx_s == bank_idx_t'(i))) begin
          mb_r[i] <= bus.db_in;
        end else begin
          mb_r[i] <= mb_r[i];
        end
      end
    end
  end

  // Flags register, CU write only.
  always_ff @(posedge clk3 or negedge nreset) begin
    if (!nreset) begin
      flags_r <= 8'h00;
    end else if (wr_flags_s) begin
      flags_r <= bus.ibus_in;
    end else begin
      flags_r <= flags_r;
    end
  end

  // Disable flag: set by reset, cleared for good by any bank-window I/O cycle.
  always_ff @(posedge clk3 or negedge nreset) begin
    if (!nreset) begin
      dis_r <= 1'b1;
    end else if (!niombr_s) begin
      dis_r <= 1'b0;
    end else begin
      dis_r <= dis_r;
    end
  end

  // IBUS read mux.
  always_comb begin
    bus.ibus_oe  = 1'b0;
    bus.ibus_out = 8'h00;
    if (rd_mbp_s) begin
      bus.ibus_oe  = 1'b1;
      bus.ibus_out = dis_r ? rom_val_s : mb_r[0];
    end else if (rd_flags_s) begin
      bus.ibus_oe  = 1'b1;
      bus.ibus_out = dis_r ? rom_val_s : flags_r;
    end else begin
      bus.ibus_oe  = 1'b0;
      bus.ibus_out = 8'h00;
    end
  end

  // DB read mux for IN cycles.
  always_comb begin
    bus.db_oe  = 1'b0;
    bus.db_out = 8'h00;
    if (io_rd_s) begin
      bus.db_oe  = 1'b1;
      bus.db_out = dis_r ? rom_val_s : mb_r[io_idx_s];
    end else begin
      bus.db_oe  = 1'b0;
      bus.db_out = 8'h00;
    end
  end

  // Address extension for AR writes.
  always_comb begin
    bus.nwrite_ar_mbx = nwrite_ar_s;
    bus.aext          = 8'h00;
    if (!nwrite_ar_s) begin
      bus.aext = dis_r ? rom_val_s : mb_r[sel_s];
    end else begin
      bus.aext = 8'h00;
    end
  end

endmodule

// File: tb/tb_mbu_bank_regs.sv
// tb_mbu_bank_regs: directed self-checking bench for mbu_bank_regs.
module tb_mbu_bank_regs;

  logic clk3;
  logic nreset;
  int   n_checks;
  int   n_fails;

  mbu_bank_regs_if bus ();

  mbu_bank_regs dut (
    .clk3   (clk3),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk3 = 1'b0;
  always #5 clk3 = ~clk3;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.t34     = 1'b1;
    bus.raddr   = 5'b00000;
    bus.waddr   = 5'b11111;
    bus.idxen   = 1'b0;
    bus.ir      = 3'd0;
    bus.ibus_in = 8'h00;
    bus.ab      = 8'h00;
    bus.db_in   = 8'h00;
    bus.nsysdev = 1'b1;
    bus.nr      = 1'b1;
    bus.nw      = 1'b1;
  endtask

  // Advance one rising edge and move #1 away from it.
  task automatic tick();
    @(posedge clk3);
    #1;
  endtask

  task automatic io_out(input logic [7:0] addr, input logic [7:0] data);
    idle();
    bus.nsysdev = 1'b0;
    bus.ab      = addr;
    bus.db_in   = data;
    bus.nw      = 1'b0;
    tick();
    idle();
  endtask

  task automatic io_in(input logic [7:0] addr);
    idle();
    bus.nsysdev = 1'b0;
    bus.ab      = addr;
    bus.nr      = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle();
    bus.nfpram_rom = 1'b1;
    nreset = 1'b0;
    #12;

    // Reset state, ROM mode then RAM mode.
    bus.waddr = 5'b00100;
    bus.raddr = 5'b01100;
    bus.t34   = 1'b0;
    #1;
    check_eq("rst_nwrite_ar", {7'd0, bus.nwrite_ar_mbx}, 8'h00);
    check_eq("rst_aext_rom", bus.aext, 8'h80);
    check_eq("rst_ibus_oe", {7'd0, bus.ibus_oe}, 8'h01);
    check_eq("rst_ibus_rom", bus.ibus_out, 8'h80);
    bus.nfpram_rom = 1'b0;
    #1;
    check_eq("rst_aext_ram", bus.aext, 8'h00);
    check_eq("rst_ibus_ram", bus.ibus_out, 8'h00);
    bus.nfpram_rom = 1'b1;
    nreset = 1'b1;
    tick();
    check_eq("dis_held_aext", bus.aext, 8'h80);

    // OUT to &0B enables the unit and stores MB3.
    io_out(8'h0B, 8'h5A);
    io_in(8'h0B);
    check_eq("in_0b_oe", {7'd0, bus.db_oe}, 8'h01);
    check_eq("in_0b_data", bus.db_out, 8'h5A);
    idle();
    bus.waddr = 5'b00111;
    #1;
    check_eq("aext_mb3", bus.aext, 8'h5A);

    // Out-of-window addresses store nothing.
    io_out(8'h8B, 8'h77);
    io_out(8'h1B, 8'h77);
    io_in(8'h8B);
    check_eq("in_8b_oe", {7'd0, bus.db_oe}, 8'h00);
    check_eq("in_8b_data", bus.db_out, 8'h00);
    io_in(8'h1B);
    check_eq("in_1b_oe", {7'd0, bus.db_oe}, 8'h00);
    io_in(8'h0B);
    check_eq("in_0b_kept", bus.db_out, 8'h5A);

    // CU write / read of MB0.
    idle();
    bus.waddr = 5'b01100;
    bus.ibus_in = 8'h12;
    tick();
    idle();
    bus.raddr = 5'b01100;
    bus.t34 = 1'b0;
    #1;
    check_eq("cu_rd_oe", {7'd0, bus.ibus_oe}, 8'h01);
    check_eq("cu_rd_mb0", bus.ibus_out, 8'h12);
    bus.t34 = 1'b1;
    #1;
    check_eq("cu_rd_t34_oe", {7'd0, bus.ibus_oe}, 8'h00);
    check_eq("cu_rd_t34_out", bus.ibus_out, 8'h00);

    // AEXT selection.
    io_out(8'h0A, 8'h33);
    io_out(8'h0E, 8'h66);
    bus.waddr = 5'b00110;
    #1;
    check_eq("ar_nwrite_6", {7'd0, bus.nwrite_ar_mbx}, 8'h00);
    check_eq("aext_mb2", bus.aext, 8'h33);
    bus.waddr = 5'b00111;
    bus.idxen = 1'b1;
    bus.ir    = 3'd6;
    #1;
    check_eq("aext_idx_mb6", bus.aext, 8'h66);
    bus.idxen = 1'b0;
    bus.waddr = 5'b01000;
    #1;
    check_eq("ar_nwrite_8", {7'd0, bus.nwrite_ar_mbx}, 8'h01);
    check_eq("aext_none", bus.aext, 8'h00);

    // Flags register.
    idle();
    bus.waddr = 5'b01101;
    bus.ibus_in = 8'hC3;
    tick();
    idle();
    bus.raddr = 5'b01101;
    bus.t34 = 1'b0;
    #1;
    check_eq("cu_rd_flags", bus.ibus_out, 8'hC3);

    // CU write beats OUT to MB0 on the same edge.
    idle();
    bus.waddr   = 5'b01100;
    bus.ibus_in = 8'hAA;
    bus.nsysdev = 1'b0;
    bus.ab      = 8'h08;
    bus.db_in   = 8'hBB;
    bus.nw      = 1'b0;
    tick();
    idle();
    bus.raddr = 5'b01100;
    bus.t34 = 1'b0;
    #1;
    check_eq("collide_cu", bus.ibus_out, 8'hAA);
    io_in(8'h08);
    check_eq("collide_io", bus.db_out, 8'hAA);

    // nr and nw both low: read happens, write suppressed.
    idle();
    bus.nsysdev = 1'b0;
    bus.ab = 8'h0D;
    bus.db_in = 8'h99;
    bus.nr = 1'b0;
    bus.nw = 1'b0;
    #1;
    check_eq("rdwr_oe", {7'd0, bus.db_oe}, 8'h01);
    check_eq("rdwr_out", bus.db_out, 8'h00);
    tick();
    io_in(8'h0D);
    check_eq("rdwr_no_store", bus.db_out, 8'h00);
    io_out(8'h0D, 8'h55);
    io_in(8'h0D);
    check_eq("mb5_stored", bus.db_out, 8'h55);

    // Mid-cycle reset with MB5 nonzero.
    #2;
    nreset = 1'b0;
    #1;
    check_eq("midrst_in_rom", bus.db_out, 8'h80);
    bus.nfpram_rom = 1'b0;
    #1;
    check_eq("midrst_in_ram", bus.db_out, 8'h00);
    bus.nfpram_rom = 1'b1;
    nreset = 1'b1;
    #1;
    check_eq("midrst_dis", bus.db_out, 8'h80);
    tick();
    check_eq("midrst_mb5_clr", bus.db_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
